// File: rtl/dcache_pkg.sv
// rtl/dcache_pkg.sv - shared field widths and request record for the dcache request arbiter
package dcache_pkg;

  localparam int ADDR_W    = 40;
  localparam int CMD_W     = 5;
  localparam int TYP_W     = 3;
  localparam int TAG_W     = 9;
  localparam int REQ_TAG_W = 8;
  localparam int DATA_W    = 64;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [TAG_W-1:0]  tag;
    logic [CMD_W-1:0]  cmd;
    logic [TYP_W-1:0]  typ;
    logic              kill;
    logic              phys;
    logic [DATA_W-1:0] data;
  } dcache_req_t;

  // Idle slot contents: everything zero except phys.
  localparam dcache_req_t REQ_RESET = '{
    addr: '0, tag: '0, cmd: '0, typ: '0, kill: 1'b0, phys: 1'b1, data: '0
  };

  function automatic dcache_req_t pack_req(
    input logic                 src,
    input logic [ADDR_W-1:0]    addr,
    input logic [REQ_TAG_W-1:0] tag,
    input logic [CMD_W-1:0]     cmd,
    input logic [TYP_W-1:0]     typ,
    input logic                 kill,
    input logic                 phys,
    input logic [DATA_W-1:0]    data
  );
    dcache_req_t r;
    r.addr = addr;
    r.tag  = {src, tag};
    r.cmd  = cmd;
    r.typ  = typ;
    r.kill = kill;
    r.phys = phys;
    r.data = data;
    return r;
  endfunction

endpackage

// File: rtl/outst_counter.sv
// rtl/outst_counter.sv - per-requester in-flight request counter
module outst_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc_i,
  input  logic         dec_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q, cnt_d;
  logic         dec_ok;

  // A response with nothing outstanding is dropped rather than wrapping.
  assign dec_ok = dec_i && (cnt_q != '0);

  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && !dec_ok) begin
      cnt_d = cnt_q + 1'b1;
    end else if (!inc_i && dec_ok) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

  a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(dec_i && (cnt_q == '0)));

endmodule

// File: rtl/dcache_req_arbiter.sv
// rtl/dcache_req_arbiter.sv - two-requester round-robin arbiter into a single dcache request port
module dcache_req_arbiter
  import dcache_pkg::*;
#(
  parameter int MAX_OUTST = 4
) (
  input  logic                 clk,
  input  logic                 reset,

  input  logic                 req0_valid,
  output logic                 req0_ready,
  input  logic [ADDR_W-1:0]    req0_addr,
  input  logic [REQ_TAG_W-1:0] req0_tag,
  input  logic [CMD_W-1:0]     req0_cmd,
  input  logic [TYP_W-1:0]     req0_typ,
  input  logic                 req0_kill,
  input  logic                 req0_phys,
  input  logic [DATA_W-1:0]    req0_data,

  input  logic                 req1_valid,
  output logic                 req1_ready,
  input  logic [ADDR_W-1:0]    req1_addr,
  input  logic [REQ_TAG_W-1:0] req1_tag,
  input  logic [CMD_W-1:0]     req1_cmd,
  input  logic [TYP_W-1:0]     req1_typ,
  input  logic                 req1_kill,
  input  logic                 req1_phys,
  input  logic [DATA_W-1:0]    req1_data,

  output logic                 cache_req_valid,
  input  logic                 cache_req_ready,
  output logic [ADDR_W-1:0]    cache_req_addr,
  output logic [TAG_W-1:0]     cache_req_tag,
  output logic [CMD_W-1:0]     cache_req_cmd,
  output logic [TYP_W-1:0]     cache_req_typ,
  output logic                 cache_req_kill,
  output logic                 cache_req_phys,
  output logic [DATA_W-1:0]    cache_req_data,

  input  logic                 cache_resp_valid,
  input  logic [TAG_W-1:0]     cache_resp_tag,
  input  logic [DATA_W-1:0]    cache_resp_data,

  output logic                 resp0_valid,
  output logic [REQ_TAG_W-1:0] resp0_tag,
  output logic [DATA_W-1:0]    resp0_data,
  output logic                 resp1_valid,
  output logic [REQ_TAG_W-1:0] resp1_tag,
  output logic [DATA_W-1:0]    resp1_data
);

  localparam logic [4:0] MAX_L = 5'(MAX_OUTST);

  dcache_req_t       slot_q, slot_d;
  logic              slot_valid_q, slot_valid_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              rr_q, rr_d;
  logic              rdy_en_q, rdy_en_d;

  logic [3:0] outst0, outst1;
  logic [4:0] load0, load1;
  logic       cache_fire, slot_free;
  logic       elig0, elig1, gnt0, gnt1;
  logic       inc0, inc1, dec0, dec1;

  assign cache_fire = slot_valid_q && cache_req_ready;
  assign slot_free  = !slot_valid_q || cache_fire;

  // The request sitting in the slot already counts against its owner's budget.
  assign load0 = {1'b0, outst0} + {4'b0, slot_valid_q && !slot_q.tag[8]};
  assign load1 = {1'b0, outst1} + {4'b0, slot_valid_q &&  slot_q.tag[8]};

  assign elig0 = req0_valid && slot_free && rdy_en_q && (load0 < MAX_L);
  assign elig1 = req1_valid && slot_free && rdy_en_q && (load1 < MAX_L);

  // rr_q names the requester that wins a tie.
  assign gnt1 = elig1 && (!elig0 || rr_q);
  assign gnt0 = elig0 && !gnt1;

  assign req0_ready = gnt0;
  assign req1_ready = gnt1;

  always_comb begin
    slot_valid_d = slot_valid_q;
    slot_d       = slot_q;
    rr_d         = rr_q;
    rdy_en_d     = 1'b1;
    data_d       = cache_fire ? slot_q.data : '0;
    if (cache_fire) begin
      slot_valid_d = 1'b0;
    end
    if (gnt0) begin
      slot_valid_d = 1'b1;
      slot_d       = pack_req(1'b0, req0_addr, req0_tag, req0_cmd, req0_typ,
                              req0_kill, req0_phys, req0_data);
      rr_d         = 1'b1;
    end else if (gnt1) begin
      slot_valid_d = 1'b1;
      slot_d       = pack_req(1'b1, req1_addr, req1_tag, req1_cmd, req1_typ,
                              req1_kill, req1_phys, req1_data);
      rr_d         = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      slot_valid_q <= 1'b0;
      slot_q       <= REQ_RESET;
      data_q       <= '0;
      rr_q         <= 1'b0;
      rdy_en_q     <= 1'b0;
    end else begin
      slot_valid_q <= slot_valid_d;
      slot_q       <= slot_d;
      data_q       <= data_d;
      rr_q         <= rr_d;
      rdy_en_q     <= rdy_en_d;
    end
  end

  assign cache_req_valid = slot_valid_q;
  assign cache_req_addr  = slot_q.addr;
  assign cache_req_tag   = slot_q.tag;
  assign cache_req_cmd   = slot_q.cmd;
  assign cache_req_typ   = slot_q.typ;
  assign cache_req_kill  = slot_q.kill;
  assign cache_req_phys  = slot_q.phys;
  assign cache_req_data  = data_q;

  assign inc0 = cache_fire && !slot_q.tag[8];
  assign inc1 = cache_fire &&  slot_q.tag[8];
  assign dec0 = cache_resp_valid && !cache_resp_tag[8];
  assign dec1 = cache_resp_valid &&  cache_resp_tag[8];

  outst_counter #(.W(4)) u_outst0 (
    .clk   (clk),
    .rst_n (reset),
    .inc_i (inc0),
    .dec_i (dec0),
    .cnt_o (outst0)
  );

  outst_counter #(.W(4)) u_outst1 (
    .clk   (clk),
    .rst_n (reset),
    .inc_i (inc1),
    .dec_i (dec1),
    .cnt_o (outst1)
  );

  assign resp0_valid = dec0;
  assign resp0_tag   = cache_resp_tag[7:0];
  assign resp0_data  = cache_resp_data;
  assign resp1_valid = dec1;
  assign resp1_tag   = cache_resp_tag[7:0];
  assign resp1_data  = cache_resp_data;

endmodule
